// File: rtl/debouncer_multi_edge.sv
// Multi-channel debouncer: per-channel synchroniser, saturating up/down integrator
// with hysteresis, a shared sample tick and registered rise/fall event pulses.
module debouncer_multi_edge #(
  parameter int WIDTH          = 4,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200,
  parameter int ACTIVE_LOW     = 0,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] glitchy_signal,
  output logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             sample_tick
);

  localparam int WRAP_W = $clog2(SAMPLE_CNT_MAX);
  localparam int SAT_W  = $clog2(PULSE_CNT_MAX + 1);
  localparam logic [WRAP_W-1:0] WRAP_LAST = WRAP_W'(SAMPLE_CNT_MAX - 1);
  localparam logic [SAT_W-1:0]  SAT_MAX   = SAT_W'(PULSE_CNT_MAX);

  logic [WRAP_W-1:0]                 r_wrap;
  logic                              r_tick;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0][SAT_W-1:0]       r_cnt;
  logic [WIDTH-1:0]                  r_deb;
  logic [WIDTH-1:0]                  r_rise;
  logic [WIDTH-1:0]                  r_fall;
  logic [WIDTH-1:0]                  w_s_in;
  logic [WIDTH-1:0]                  w_s_sync;
  logic [WIDTH-1:0]                  w_next_deb;

  assign w_s_in   = (ACTIVE_LOW != 0) ? ~glitchy_signal : glitchy_signal;
  assign w_s_sync = r_sync[SYNC_STAGES-1];

  assign debounced_signal = r_deb;
  assign rise_pulse       = r_rise;
  assign fall_pulse       = r_fall;
  assign sample_tick      = r_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap <= '0;
      r_tick <= 1'b0;
    end else if (en) begin
      if (r_wrap == WRAP_LAST) begin
        r_wrap <= '0;
        r_tick <= 1'b1;
      end else begin
        r_wrap <= r_wrap + WRAP_W'(1);
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  // Stage 0 takes the (polarity-corrected) pin; the last stage feeds the integrators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_s_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_tick && en) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (w_s_sync[i] && (r_cnt[i] < SAT_MAX)) begin
          r_cnt[i] <= r_cnt[i] + SAT_W'(1);
        end else if (!w_s_sync[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - SAT_W'(1);
        end
      end
    end
  end

  // Output only moves at the integrator rails; in between it holds (hysteresis).
  always_comb begin
    w_next_deb = r_deb;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (r_cnt[i] == SAT_MAX) begin
        w_next_deb[i] = 1'b1;
      end else if (r_cnt[i] == '0) begin
        w_next_deb[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb  <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_deb  <= w_next_deb;
      r_rise <= w_next_deb & ~r_deb;
      r_fall <= ~w_next_deb & r_deb;
    end
  end

endmodule

// File: doc/debouncer_multi_edge.md
Name: debouncer_multi_edge

Overview:
- Parametrised multi-channel debouncer for push-buttons and switches. It generalises the single-threshold debouncer with:
  - per-channel input synchronisers;
  - a symmetric up/down integrator with hysteresis, so release is debounced as well as press;
  - optional active-low inputs;
  - a global sample enable;
  - one-cycle rise/fall event pulses.
- Sits between the board I/O pins and the user logic (FSMs, counters) in the lab top levels.

Parameters:
- WIDTH, 4, number of independent input channels.
- SAMPLE_CNT_MAX, 62500, clock cycles per sample tick; must be >= 2.
- PULSE_CNT_MAX, 200, integrator saturation value in sample ticks; must be >= 1.
- ACTIVE_LOW, 0, if 1 every input is inverted before synchronisation (a pressed active-low button reads as 1).
- SYNC_STAGES, 2, synchroniser flop depth per channel; must be >= 2.
- Derived, not overridable:
  - WRAP_W = $clog2(SAMPLE_CNT_MAX)
  - SAT_W = $clog2(PULSE_CNT_MAX+1)

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  sample enable; 0 freezes sampling.
- glitchy_signal  input  WIDTH  raw asynchronous inputs.
- debounced_signal  output  WIDTH  debounced level per channel.
- rise_pulse  output  WIDTH  one-cycle pulse on a debounced 0->1 transition.
- fall_pulse  output  WIDTH  one-cycle pulse on a debounced 1->0 transition.
- sample_tick  output  1  registered one-cycle strobe, one per sample period.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low; assertion takes effect immediately, without waiting for a clock edge.
- Reset values, all zero, with no rise/fall pulse on reset release:
  - wrap counter, sample_tick;
  - synchroniser flops;
  - integrators;
  - debounced_signal, rise_pulse, fall_pulse.
- Input path: s_in[i] = glitchy_signal[i] XOR ACTIVE_LOW, passed through SYNC_STAGES flops. s_sync[i] is the last stage.
- Wrap counter (one, shared by all channels):
  - en=1: increments each cycle. When the value is SAMPLE_CNT_MAX-1 it loads 0 and sample_tick is registered 1 for the next cycle; otherwise sample_tick is 0.
  - en=0: counter holds its value and sample_tick is 0.
  - Tick period is exactly SAMPLE_CNT_MAX cycles while en stays 1.
- Integrator cnt[i] (SAT_W bits), updated only in cycles where sample_tick=1 and en=1:
  - s_sync[i]=1 and cnt<PULSE_CNT_MAX: cnt+1;
  - s_sync[i]=0 and cnt>0: cnt-1;
  - otherwise hold, saturating at both ends with no wrap.
- Output state, registered, per channel:
  - next_deb = 1 if cnt==PULSE_CNT_MAX, 0 if cnt==0, else current debounced (hysteresis).
  - debounced_signal lags cnt by one cycle.
- Edge pulses, registered in the same edge as debounced_signal:
  - rise_pulse[i] <= next_deb & ~debounced[i];
  - fall_pulse[i] <= ~next_deb & debounced[i].
  - Each pulse is exactly one cycle. The two are never high together on the same channel.
- Latency: input stable high from a cleared channel gives debounced=1 after SYNC_STAGES cycles + PULSE_CNT_MAX ticks + 1 cycle, with tick phase jitter up to SAMPLE_CNT_MAX cycles. Release is symmetric.
- Glitches: a pulse shorter than PULSE_CNT_MAX net ticks never changes the output. Alternating samples keep cnt between bounds and hold the output.
- en deasserted mid-operation: all counters and outputs hold, pulses return to 0. On en=1, sampling resumes from the frozen wrap count; nothing is reset.
- Channels are fully independent and may transition in the same cycle.
- Reset mid-operation: all state returns to reset values immediately. After release the output must re-integrate from 0.

Test Plan:
(Parameters unless stated: WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, SYNC_STAGES=2, ACTIVE_LOW=0.)
- Reset:
  - Stimulus: assert rst_n=0 between clock edges while debounced_signal=2'b01.
  - Required: all outputs 0 before the next edge; no pulse after release.
- Press:
  - Stimulus: en=1, glitchy_signal=2'b01 held.
  - Required: sample_tick high 1 cycle in every 4. debounced_signal[0] rises 1 cycle after the 3rd tick that samples 1. rise_pulse[0] high exactly that cycle. Channel 1 stays 0.
- Glitch:
  - Stimulus: channel 0 high for 1 tick then low.
  - Required: cnt goes 1 then 0; debounced_signal and both pulses remain 0.
- Hysteresis/release:
  - Stimulus: with debounced_signal[0]=1, input low for 2 ticks then high.
  - Required: cnt goes 3->1->2 and the output stays 1.
  - Stimulus: then low for 3 ticks.
  - Required: output 0 and fall_pulse[0] high for one cycle.
- Enable/polarity:
  - Stimulus: en=0 for 20 cycles with input high.
  - Required: no sample_tick and counters frozen; after en=1, debounce completes the remaining ticks only.
  - Stimulus: with ACTIVE_LOW=1, input held 0.
  - Required: debounced_signal=1.
- Simultaneous:
  - Stimulus: both channels driven high on the same cycle.
  - Required: rise_pulse=2'b11 in the same single cycle.
